alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `ALU` instance among `NUM_REQ` requesters. It accepts one operation at a time from the winning requester and registers its operands into the ALU. It captures the result and returns it with the requester ID over a valid/ready response channel. It sits between the board-level input sources (switch/button front end, UART command decoder) and the single ALU datapath.

---
 rtl/alu_arbiter.sv | 179 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU among NUM_REQ requesters and returns results over valid/ready.
// Optional opcode check enabled by defining ALU_ARB_OPCHK_EN; otherwise o_rsp_err is tied to 0.

module alu #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
) (
    input  logic [NB_DATA-1:0] a,
    input  logic [NB_DATA-1:0] b,
    input  logic [NB_OP-1:0]   op,
    output logic [NB_DATA-1:0] result
);
    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);

    // Shift amount is the whole B operand; oversized shifts saturate to fill bits.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_SRA:  result = NB_DATA'($signed(a) >>> b);
            OP_SRL:  result = a >> b;
            default: result = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned NB_DATA = 8,
    parameter  int unsigned NB_OP   = 6,
    localparam int unsigned NB_ID   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*NB_DATA-1:0] i_data_a,
    input  logic [NUM_REQ*NB_DATA-1:0] i_data_b,
    input  logic [NUM_REQ*NB_OP-1:0]   i_op,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic                       o_busy,
    input  logic                       i_rsp_ready,
    output logic                       o_rsp_valid,
    output logic [NB_DATA-1:0]         o_rsp_result,
    output logic [NB_ID-1:0]           o_rsp_id,
    output logic                       o_rsp_err
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state;
    logic [NB_ID-1:0]   ptr;
    logic [NB_ID-1:0]   win;
    logic [NB_ID-1:0]   ptr_next;
    logic               found;
    logic [NB_DATA-1:0] a_q;
    logic [NB_DATA-1:0] b_q;
    logic [NB_OP-1:0]   op_q;
    logic [NB_ID-1:0]   id_q;
    logic [NB_DATA-1:0] alu_result;
    int unsigned        idx;

    logic [NB_DATA-1:0] a_arr  [NUM_REQ];
    logic [NB_DATA-1:0] b_arr  [NUM_REQ];
    logic [NB_OP-1:0]   op_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign a_arr[k]  = i_data_a[k*NB_DATA +: NB_DATA];
        assign b_arr[k]  = i_data_b[k*NB_DATA +: NB_DATA];
        assign op_arr[k] = i_op[k*NB_OP +: NB_OP];
    end

    // Scan downward so the last hit is the first requester at or after ptr.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            idx = 32'(ptr) + 32'(i);
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (i_req[NB_ID'(idx)]) begin
                win   = NB_ID'(idx);
                found = 1'b1;
            end
        end
    end

    assign ptr_next = (win == NB_ID'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    // Grant is suppressed during reset so nothing is advertised as accepted.
    always_comb begin
        o_grant = '0;
        if (state == IDLE && i_rst_n && found) o_grant[win] = 1'b1;
    end

    alu #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= '0;
            o_busy       <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_rsp_result <= '0;
            o_rsp_id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        a_q    <= a_arr[win];
                        b_q    <= b_arr[win];
                        op_q   <= op_arr[win];
                        id_q   <= win;
                        ptr    <= ptr_next;
                        o_busy <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    o_rsp_result <= alu_result;
                    o_rsp_id     <= id_q;
                    o_rsp_valid  <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    o_busy      <= 1'b0;
                    o_rsp_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_OPCHK_EN
    logic op_known;

    assign op_known = op_q inside {NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
                                   NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b000011),
                                   NB_OP'(6'b000010), NB_OP'(6'b100111)};

    // Error flag travels with the result and holds through backpressure.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rsp_err <= 1'b0;
        end else if (state == EXEC) begin
            o_rsp_err <= ~op_known;
        end
    end
`else
    assign o_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter against a transaction-level round-robin/ALU reference model.
module tb_alu_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned NB_DATA = 8;
    localparam int unsigned NB_OP   = 6;
    localparam int unsigned NB_ID   = 2;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*NB_DATA-1:0] data_a;
    logic [NUM_REQ*NB_DATA-1:0] data_b;
    logic [NUM_REQ*NB_OP-1:0]   op_bus;
    logic [NUM_REQ-1:0]         grant;
    logic                       busy;
    logic                       rsp_ready;
    logic                       rsp_valid;
    logic [NB_DATA-1:0]         rsp_result;
    logic [NB_ID-1:0]           rsp_id;
    logic                       rsp_err;

    logic [7:0] ta  [NUM_REQ];
    logic [7:0] tbv [NUM_REQ];
    logic [5:0] top [NUM_REQ];
    logic [3:0] mask;
    int         mptr;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        data_a = '0;
        data_b = '0;
        op_bus = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            data_a[k*8 +: 8] = ta[k];
            data_b[k*8 +: 8] = tbv[k];
            op_bus[k*6 +: 6] = top[k];
        end
    end

    alu_arbiter #(.NUM_REQ(NUM_REQ), .NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (req),
        .i_data_a     (data_a),
        .i_data_b     (data_b),
        .i_op         (op_bus),
        .o_grant      (grant),
        .o_busy       (busy),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_result (rsp_result),
        .o_rsp_id     (rsp_id),
        .o_rsp_err    (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_alu(input int a, input int b, input int op);
        int sa;
        int r;
        sa = (a >= 128) ? a - 256 : a;
        case (op)
            'h20: r = a + b;
            'h22: r = a - b;
            'h24: r = a & b;
            'h25: r = a | b;
            'h26: r = a ^ b;
            'h27: r = ~(a | b);
            'h03: begin
                if (b >= 8) r = (sa < 0) ? -1 : 0;
                else if (sa >= 0) r = sa / (1 << b);
                else r = -((-sa + (1 << b) - 1) / (1 << b));
            end
            'h02: r = (b >= 8) ? 0 : a / (1 << b);
            default: r = 0;
        endcase
        return r & 255;
    endfunction

    function automatic int ref_err(input int op);
`ifdef ALU_ARB_OPCHK_EN
        return (op inside {'h20, 'h22, 'h24, 'h25, 'h26, 'h03, 'h02, 'h27}) ? 0 : 1;
`else
        return (op < 0) ? 1 : 0;
`endif
    endfunction

    function automatic int pick(input logic [3:0] m, input int p);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic set_opnd(input int k, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        ta[k]  = a;
        tbv[k] = b;
        top[k] = op;
    endtask

    task automatic rand_opnd(input int k);
        logic [5:0] ops [8];
        int         sel;
        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};
        sel = $urandom_range(0, 9);
        ta[k]  = 8'($urandom);
        tbv[k] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
        top[k] = (sel < 8) ? ops[sel] : 6'($urandom);
    endtask

    // One IDLE->EXEC->RESP->IDLE transaction; called at a negedge with the DUT idle.
    task automatic run_txn(input int delay, input bit hold);
        int w;
        int er;
        int ee;
        req = mask;
        #1;
        w = pick(mask, mptr);
        if (w < 0) begin
            check("idle_grant", 32'(grant), 0);
            check("idle_busy", 32'(busy), 0);
            @(negedge clk);
            return;
        end
        check("grant", 32'(grant), 32'(1 << w));
        check("busy_idle", 32'(busy), 0);
        check("valid_idle", 32'(rsp_valid), 0);
        er   = ref_alu(int'(ta[w]), int'(tbv[w]), int'(top[w]));
        ee   = ref_err(int'(top[w]));
        mptr = (w + 1) % NUM_REQ;
        if (!hold) mask[w] = 1'b0;
        @(negedge clk);
        check("busy_exec", 32'(busy), 1);
        check("valid_exec", 32'(rsp_valid), 0);
        check("grant_exec", 32'(grant), 0);
        req       = mask;
        rsp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        rsp_ready = (delay == 0);
        check("valid_resp", 32'(rsp_valid), 1);
        check("result", 32'(rsp_result), 32'(er));
        check("id", 32'(rsp_id), 32'(w));
        check("err", 32'(rsp_err), 32'(ee));
        check("grant_resp", 32'(grant), 0);
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            rsp_ready = (k == delay - 1);
            check("valid_hold", 32'(rsp_valid), 1);
            check("result_hold", 32'(rsp_result), 32'(er));
            check("id_hold", 32'(rsp_id), 32'(w));
            check("err_hold", 32'(rsp_err), 32'(ee));
            check("grant_hold", 32'(grant), 0);
        end
        @(negedge clk);
        check("valid_done", 32'(rsp_valid), 0);
        check("busy_done", 32'(busy), 0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req       = '0;
        mask      = '0;
        mptr      = 0;
        for (int k = 0; k < NUM_REQ; k++) rand_opnd(k);

        // Reset with random requests present
        repeat (3) begin
            @(negedge clk);
            req = 4'($urandom);
            #1;
            check("rst_grant", 32'(grant), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_valid", 32'(rsp_valid), 0);
            check("rst_result", 32'(rsp_result), 0);
            check("rst_id", 32'(rsp_id), 0);
            check("rst_err", 32'(rsp_err), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = '0;

        // Round robin with all requesting, then alternating pair
        mask = 4'b1111;
        repeat (5) run_txn(0, 1'b1);
        mask = 4'b1010;
        repeat (3) run_txn(0, 1'b1);

        // Backpressure on SRA with a competing requester waiting
        set_opnd(2, 8'h80, 8'h02, 6'b000011);
        set_opnd(0, 8'h7F, 8'h01, 6'b100000);
        mask = 4'b0101;
        run_txn(5, 1'b0);
        run_txn(0, 1'b0);
        set_opnd(2, 8'h80, 8'h02, 6'b000010);
        mask = 4'b0100;
        run_txn(2, 1'b0);

        // Unsupported opcode
        set_opnd(1, 8'h05, 8'h03, 6'b111111);
        mask = 4'b0010;
        run_txn(0, 1'b0);

        // Reset while in EXEC drops the operation and clears the pointer
        mask = 4'b1111;
        req  = mask;
        #1;
        check("pre_rst_grant", 32'(grant), 32'(1 << pick(mask, mptr)));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_valid", 32'(rsp_valid), 0);
        rst_n = 1'b1;
        mptr  = 0;
        run_txn(1, 1'b1);

        // Randomized traffic
        repeat (60) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!mask[k] && $urandom_range(0, 2) != 0) begin
                    mask[k] = 1'b1;
                    rand_opnd(k);
                end else if (mask[k] && $urandom_range(0, 7) == 0) begin
                    mask[k] = 1'b0;
                end
            end
            if ($urandom_range(0, 9) == 0) mask = '0;
            run_txn($urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
